// File: rtl/cluster_pe_acc_pkg.sv
// Shared types and width helpers for the cluster processing element.
// Holds the FSM state enum and the derived widths AXIS_W, DEPTH_W and SUM_W
// (for the default parameter set) plus functions that derive them for any
// parameterisation.
package cluster_pe_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_DIV   = 2'd2,
        ST_CMP   = 2'd3
    } state_e;

    // Axis index width; at least one bit so a single-dimension build still has a port.
    function automatic int unsigned calc_axis_w(input int unsigned dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    function automatic int unsigned calc_depth_w(input int unsigned max_depth);
        return (max_depth > 1) ? $clog2(max_depth) : 1;
    endfunction

    // Accumulator width: a full count of full-scale coordinates never wraps.
    function automatic int unsigned calc_sum_w(input int unsigned data_w, input int unsigned count_w);
        return data_w + count_w;
    endfunction

    localparam int unsigned AXIS_W  = calc_axis_w(3);
    localparam int unsigned DEPTH_W = calc_depth_w(16);
    localparam int unsigned SUM_W   = calc_sum_w(8, 16);

endpackage

// File: rtl/cluster_pe_acc_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first bit is produced on the start edge, so the full quotient is valid
// DIVIDEND_W edges after start, with done high for that one cycle.
// Ports: clk, rst (sync active-low), start, dividend, divisor,
//        quotient (low QUOT_W bits of the truncated quotient), done.
module seq_divider #(
    parameter int unsigned DIVIDEND_W = 24,
    parameter int unsigned DIVISOR_W  = 16,
    parameter int unsigned QUOT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [QUOT_W-1:0]     quotient,
    output logic                  done
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DIVISOR_W-1:0]  rem_in_c;
    logic [DIVIDEND_W-1:0] quo_in_c;
    logic [DIVISOR_W-1:0]  dsr_c;
    logic [DIVISOR_W:0]    shifted_c;
    logic                  fits_c;
    logic [DIVISOR_W-1:0]  rem_nxt_c;
    logic [DIVIDEND_W-1:0] quo_nxt_c;

    // One restoring step; on start the step runs on the fresh operands.
    always_comb begin
        rem_in_c  = start ? '0 : rem_q;
        quo_in_c  = start ? dividend : quo_q;
        dsr_c     = start ? divisor : dsr_q;
        shifted_c = {rem_in_c, quo_in_c[DIVIDEND_W-1]};
        fits_c    = (shifted_c >= {1'b0, dsr_c});
        rem_nxt_c = fits_c ? DIVISOR_W'(shifted_c - {1'b0, dsr_c}) : DIVISOR_W'(shifted_c);
        quo_nxt_c = {quo_in_c[DIVIDEND_W-2:0], fits_c};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else if (start) begin
            rem_q <= rem_nxt_c;
            dsr_q <= divisor;
            quo_q <= quo_nxt_c;
            cnt_q <= CNT_W'(DIVIDEND_W - 1);
            done  <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q <= rem_nxt_c;
            quo_q <= quo_nxt_c;
            cnt_q <= CNT_W'(cnt_q - 1'b1);
            done  <= (cnt_q == CNT_W'(1));
        end else begin
            done  <= 1'b0;
        end
    end

    assign quotient = quo_q[QUOT_W-1:0];

endmodule

// File: rtl/cluster_pe_acc.sv
// k-means cluster processing element sitting on a kd-tree node.
// Streams points (reporting which side of the split plane they fall on),
// accumulates the accepted ones, and on update replaces the center with the
// mean of the accumulated points using a shared sequential divider.
// Ports: clk, rst (sync active-low); init/center_in/depth_in load the node;
//        start_iter clears accumulation; pt_valid/pt_ready/pt_accept/point_in
//        stream points; point_out/pt_out_valid/go_left report a transfer;
//        update triggers the mean; center_out, stable, busy, overflow,
//        count_out report state.
module cluster_pe_acc
    import cluster_pe_acc_pkg::*;
#(
    parameter int unsigned DIM       = 3,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_DEPTH = 16,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  init,
    input  logic                                  start_iter,
    input  logic                                  pt_valid,
    output logic                                  pt_ready,
    input  logic                                  pt_accept,
    input  logic                                  update,
    input  logic [DIM*DATA_W-1:0]                 center_in,
    input  logic [DIM*DATA_W-1:0]                 point_in,
    input  logic [calc_depth_w(MAX_DEPTH)-1:0]    depth_in,
    output logic [DIM*DATA_W-1:0]                 center_out,
    output logic [DIM*DATA_W-1:0]                 point_out,
    output logic                                  pt_out_valid,
    output logic                                  go_left,
    output logic                                  stable,
    output logic                                  busy,
    output logic                                  overflow,
    output logic [COUNT_W-1:0]                    count_out
);

    localparam int unsigned AXIS_BITS  = calc_axis_w(DIM);
    localparam int unsigned DEPTH_BITS = calc_depth_w(MAX_DEPTH);
    localparam int unsigned SUM_BITS   = calc_sum_w(DATA_W, COUNT_W);

    state_e state_q, state_nxt_c;

    logic [DATA_W-1:0]     center_q     [DIM];
    logic [DATA_W-1:0]     new_center_q [DIM];
    logic [SUM_BITS-1:0]   sum_q        [DIM];
    logic [COUNT_W-1:0]    count_q;
    logic [DEPTH_BITS-1:0] depth_q;
    logic [AXIS_BITS-1:0]  dim_q;

    logic [DATA_W-1:0]     pt_c [DIM];
    logic [AXIS_BITS-1:0]  axis_c;
    logic                  free_c, do_init_c, do_clear_c, do_update_c, xfer_c;
    logic                  dim_last_c, div_start_c, same_c;
    logic [AXIS_BITS-1:0]  div_sel_c;
    logic [DATA_W-1:0]     div_quot;
    logic                  div_done;

    // Control decode: priority init > start_iter > update > point transfer.
    always_comb begin
        for (int d = 0; d < DIM; d++) begin
            pt_c[d] = point_in[d*DATA_W +: DATA_W];
        end
        axis_c      = AXIS_BITS'(32'(depth_q) % DIM);
        free_c      = (state_q == ST_IDLE) || (state_q == ST_READY);
        do_init_c   = free_c && init;
        do_clear_c  = free_c && !init && start_iter;
        do_update_c = (state_q == ST_READY) && !init && !start_iter && update;
        pt_ready    = (state_q == ST_READY) && !init && !start_iter && !update;
        xfer_c      = pt_valid && pt_ready;
        dim_last_c  = (dim_q == AXIS_BITS'(DIM - 1));
        // Dimension 0 starts on the update edge; the rest chain off done.
        div_start_c = do_update_c || ((state_q == ST_DIV) && div_done && !dim_last_c);
        div_sel_c   = ((state_q == ST_DIV) && !dim_last_c) ? AXIS_BITS'(dim_q + 1'b1) : '0;
        same_c      = 1'b1;
        for (int d = 0; d < DIM; d++) begin
            if (new_center_q[d] != center_q[d]) same_c = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_c = state_q;
        case (state_q)
            ST_IDLE:  if (init) state_nxt_c = ST_READY;
            ST_READY: if (do_update_c) state_nxt_c = ST_DIV;
            ST_DIV:   if (div_done && dim_last_c) state_nxt_c = ST_CMP;
            ST_CMP:   state_nxt_c = ST_READY;
            default:  state_nxt_c = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_nxt_c;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int d = 0; d < DIM; d++) begin
                center_q[d]     <= '0;
                new_center_q[d] <= '0;
                sum_q[d]        <= '0;
            end
            count_q      <= '0;
            depth_q      <= '0;
            dim_q        <= '0;
            stable       <= 1'b0;
            overflow     <= 1'b0;
            point_out    <= '0;
            pt_out_valid <= 1'b0;
            go_left      <= 1'b0;
        end else begin
            pt_out_valid <= xfer_c;
            if (xfer_c) begin
                point_out <= point_in;
                go_left   <= (pt_c[axis_c] < center_q[axis_c]);
            end

            if (do_init_c) begin
                for (int d = 0; d < DIM; d++) begin
                    center_q[d] <= center_in[d*DATA_W +: DATA_W];
                    sum_q[d]    <= '0;
                end
                depth_q  <= depth_in;
                count_q  <= '0;
                stable   <= 1'b0;
                overflow <= 1'b0;
            end else if (do_clear_c) begin
                for (int d = 0; d < DIM; d++) sum_q[d] <= '0;
                count_q  <= '0;
                overflow <= 1'b0;
            end else if (xfer_c && pt_accept) begin
                // A full counter drops the point rather than wrapping.
                if (count_q == '1) begin
                    overflow <= 1'b1;
                end else begin
                    for (int d = 0; d < DIM; d++) sum_q[d] <= sum_q[d] + SUM_BITS'(pt_c[d]);
                    count_q <= COUNT_W'(count_q + 1'b1);
                end
            end

            if (do_update_c) dim_q <= '0;

            // Capture each dimension's mean; an empty cluster keeps its center.
            if ((state_q == ST_DIV) && div_done) begin
                new_center_q[dim_q] <= (count_q == '0) ? center_q[dim_q] : div_quot;
                if (!dim_last_c) dim_q <= AXIS_BITS'(dim_q + 1'b1);
            end

            if (state_q == ST_CMP) begin
                for (int d = 0; d < DIM; d++) center_q[d] <= new_center_q[d];
                stable <= same_c;
            end
        end
    end

    seq_divider #(
        .DIVIDEND_W (SUM_BITS),
        .DIVISOR_W  (COUNT_W),
        .QUOT_W     (DATA_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (sum_q[div_sel_c]),
        .divisor  (count_q),
        .quotient (div_quot),
        .done     (div_done)
    );

    always_comb begin
        center_out = '0;
        for (int d = 0; d < DIM; d++) center_out[d*DATA_W +: DATA_W] = center_q[d];
    end

    assign busy      = (state_q == ST_DIV) || (state_q == ST_CMP);
    assign count_out = count_q;

endmodule

// File: tb/tb_cluster_pe_acc.sv
// Self-checking bench for cluster_pe_acc: a behavioural model (means by plain
// division, a busy countdown) is advanced every clock and compared with the
// DUT, with directed scenarios plus a randomized phase.
module tb_cluster_pe_acc;

    localparam int DIM     = 3;
    localparam int DATA_W  = 8;
    localparam int COUNT_W = 16;
    localparam int SUM_W   = DATA_W + COUNT_W;
    localparam int LAT     = DIM * SUM_W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, init, start_iter, pt_valid, pt_accept, update;
    logic [DIM*DATA_W-1:0]  center_in, point_in;
    logic [3:0]             depth_in;
    logic                   pt_ready, pt_out_valid, go_left, stable, busy, overflow;
    logic [DIM*DATA_W-1:0]  center_out, point_out;
    logic [COUNT_W-1:0]     count_out;

    cluster_pe_acc #(.DIM(DIM), .DATA_W(DATA_W), .MAX_DEPTH(16), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .init(init), .start_iter(start_iter),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_accept(pt_accept),
        .update(update), .center_in(center_in), .point_in(point_in),
        .depth_in(depth_in), .center_out(center_out), .point_out(point_out),
        .pt_out_valid(pt_out_valid), .go_left(go_left), .stable(stable),
        .busy(busy), .overflow(overflow), .count_out(count_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    bit      m_inited, m_ovf, m_stable, m_pov, m_goleft;
    int      m_busy, m_count, m_axis;
    int      m_center[DIM];
    int      m_pending[DIM];
    int      m_pout[DIM];
    longint  m_sum[DIM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DIM*DATA_W-1:0] pack_center();
        logic [DIM*DATA_W-1:0] r;
        r = '0;
        for (int d = 0; d < DIM; d++) r[d*DATA_W +: DATA_W] = 8'(m_center[d]);
        return r;
    endfunction

    function automatic logic [DIM*DATA_W-1:0] pack_pout();
        logic [DIM*DATA_W-1:0] r;
        r = '0;
        for (int d = 0; d < DIM; d++) r[d*DATA_W +: DATA_W] = 8'(m_pout[d]);
        return r;
    endfunction

    function automatic logic [DIM*DATA_W-1:0] pack3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic int coord(input logic [DIM*DATA_W-1:0] v, input int d);
        return int'(v[d*DATA_W +: DATA_W]);
    endfunction

    function automatic bit exp_ready();
        return m_inited && (m_busy == 0) && !init && !start_iter && !update;
    endfunction

    // Apply the inputs seen at one rising edge to the model.
    task automatic model_edge();
        bit same;
        if (!rst) begin
            m_inited = 0; m_ovf = 0; m_stable = 0; m_pov = 0; m_goleft = 0;
            m_busy = 0; m_count = 0; m_axis = 0;
            for (int d = 0; d < DIM; d++) begin
                m_center[d] = 0; m_pending[d] = 0; m_pout[d] = 0; m_sum[d] = 0;
            end
            return;
        end
        m_pov = 0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                same = 1;
                for (int d = 0; d < DIM; d++) if (m_pending[d] != m_center[d]) same = 0;
                for (int d = 0; d < DIM; d++) m_center[d] = m_pending[d];
                m_stable = same;
            end
            return;
        end
        if (init) begin
            for (int d = 0; d < DIM; d++) begin
                m_center[d] = coord(center_in, d);
                m_sum[d] = 0;
            end
            m_axis = int'(depth_in) % DIM;
            m_count = 0; m_stable = 0; m_ovf = 0; m_inited = 1;
        end else if (!m_inited) begin
            // nothing but init leaves IDLE
        end else if (start_iter) begin
            for (int d = 0; d < DIM; d++) m_sum[d] = 0;
            m_count = 0; m_ovf = 0;
        end else if (update) begin
            for (int d = 0; d < DIM; d++)
                m_pending[d] = (m_count == 0) ? m_center[d] : int'((m_sum[d] / m_count) % 256);
            m_busy = LAT;
        end else if (pt_valid) begin
            m_pov = 1;
            for (int d = 0; d < DIM; d++) m_pout[d] = coord(point_in, d);
            m_goleft = coord(point_in, m_axis) < m_center[m_axis];
            if (pt_accept) begin
                if (m_count == (1 << COUNT_W) - 1) m_ovf = 1;
                else begin
                    for (int d = 0; d < DIM; d++) m_sum[d] += coord(point_in, d);
                    m_count++;
                end
            end
        end
    endtask

    // One clock: check pt_ready before the edge, then all registered outputs after it.
    task automatic step();
        #1;
        check("pt_ready", 64'(pt_ready), 64'(exp_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check("center_out",   64'(center_out),   64'(pack_center()));
        check("point_out",    64'(point_out),    64'(pack_pout()));
        check("pt_out_valid", 64'(pt_out_valid), 64'(m_pov));
        check("go_left",      64'(go_left),      64'(m_goleft));
        check("stable",       64'(stable),       64'(m_stable));
        check("busy",         64'(busy),         64'(m_busy > 0));
        check("overflow",     64'(overflow),     64'(m_ovf));
        check("count_out",    64'(count_out),    64'(m_count));
    endtask

    task automatic quiet();
        rst = 1; init = 0; start_iter = 0; pt_valid = 0; pt_accept = 0; update = 0;
    endtask

    task automatic send_point(input int a, input int b, input int c, input bit acc);
        quiet();
        pt_valid = 1; pt_accept = acc; point_in = pack3(a, b, c);
        step();
        quiet();
    endtask

    task automatic pulse_start();
        quiet(); start_iter = 1; step(); quiet();
    endtask

    // Issue update and run until the model reports idle; returns busy cycles seen.
    task automatic do_update(output int busy_cycles);
        quiet(); update = 1; step(); quiet();
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < LAT + 4 && m_busy > 0; i++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    int bc;

    initial begin
        quiet(); rst = 0; center_in = '0; point_in = '0; depth_in = '0;
        step(); step();
        check("reset_center_lit", 64'(center_out), 64'(0));
        check("reset_ready_lit",  64'(pt_ready), 64'(0));
        quiet(); step();
        check("idle_ready_lit", 64'(pt_ready), 64'(0));

        // Load node and route one point without accepting it.
        quiet(); init = 1; center_in = pack3(10, 20, 30); depth_in = 4'd4; step(); quiet();
        check("init_center_lit", 64'(center_out), 64'h1E140A);
        send_point(5, 25, 0, 0);
        check("route_pout_lit",  64'(point_out), 64'h001905);
        check("route_left_lit",  64'(go_left), 64'(0));
        check("route_valid_lit", 64'(pt_out_valid), 64'(1));
        quiet(); step();
        check("valid_drop_lit", 64'(pt_out_valid), 64'(0));

        // Mean of two points.
        send_point(1, 2, 3, 1);
        send_point(3, 4, 5, 1);
        do_update(bc);
        check("busy_len_lit",   64'(bc), 64'(73));
        check("mean_lit",       64'(center_out), 64'h040302);
        check("mean_stable_lit", 64'(stable), 64'(0));
        check("mean_count_lit", 64'(count_out), 64'(2));

        // Truncated mean, then convergence.
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            send_point(1, 1, 1, 1);
            send_point(2, 2, 2, 1);
            do_update(bc);
            check("trunc_lit", 64'(center_out), 64'h010101);
            check("converge_lit", 64'(stable), 64'(r));
        end

        // Empty cluster keeps its center.
        pulse_start();
        do_update(bc);
        check("empty_center_lit", 64'(center_out), 64'h010101);
        check("empty_stable_lit", 64'(stable), 64'(1));

        // Points offered while busy are refused.
        send_point(9, 9, 9, 1);
        quiet(); update = 1; step(); quiet();
        for (int i = 0; i < 10; i++) begin
            pt_valid = 1; pt_accept = 1; point_in = pack3(50, 60, 70); step();
        end
        quiet();
        while (m_busy > 0) step();
        check("busy_no_acc_lit", 64'(count_out), 64'(1));
        check("single_mean_lit", 64'(center_out), 64'h090909);

        // Reset in the middle of a divide.
        quiet(); update = 1; step(); quiet();
        for (int i = 0; i < 19; i++) step();
        rst = 0; step(); quiet();
        check("midreset_center_lit", 64'(center_out), 64'(0));
        check("midreset_busy_lit",   64'(busy), 64'(0));

        // Randomized traffic.
        quiet(); init = 1; center_in = 24'($urandom); depth_in = 4'($urandom); step(); quiet();
        for (int i = 0; i < 3000; i++) begin
            int r;
            quiet();
            r = int'($urandom_range(0, 999));
            rst        = (r < 3) ? 1'b0 : 1'b1;
            init       = (r >= 3 && r < 15);
            start_iter = (r >= 15 && r < 35);
            update     = (r >= 35 && r < 60);
            pt_valid   = ($urandom_range(0, 9) < 6);
            pt_accept  = ($urandom_range(0, 9) < 7);
            point_in   = 24'($urandom);
            center_in  = 24'($urandom);
            depth_in   = 4'($urandom);
            step();
        end
        quiet();
        for (int i = 0; i < LAT + 2; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
